// File: rtl/equiv_vector_sequencer_if.sv
// Stimulus/compare bus between the vector sequencer and its environment.
// The master side is the sequencer: it addresses the vector ROM, drives the
// shared stimulus bus, and reports compare results and run status.
interface equiv_vector_sequencer_if #(
    parameter int IN_W  = 79,
    parameter int OUT_W = 152,
    parameter int IDX_W = 5,
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] vec_addr;
    logic [IN_W-1:0]  vec_data;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] y_ref;
    logic [OUT_W-1:0] y_syn;
    logic             cmp_strobe;
    logic [IDX_W-1:0] cmp_idx;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             first_fail_vld;
    logic [IDX_W-1:0] first_fail_idx;

    modport master (
        input  start, abort, vec_data, y_ref, y_syn,
        output vec_addr, stim, cmp_strobe, cmp_idx, busy, done, pass,
               mismatch_cnt, first_fail_vld, first_fail_idx
    );

    modport slave (
        output start, abort, vec_data, y_ref, y_syn,
        input  vec_addr, stim, cmp_strobe, cmp_idx, busy, done, pass,
               mismatch_cnt, first_fail_vld, first_fail_idx
    );
endinterface

// File: rtl/equiv_vector_sequencer.sv
// Equivalence-run vector sequencer: fetches each vector from a synchronous
// ROM, applies it to both DUTs, waits a settle window, compares y_ref with
// y_syn and accumulates mismatch statistics for the run.
module equiv_vector_sequencer #(
    parameter int IN_W    = 79,
    parameter int OUT_W   = 152,
    parameter int NUM_VEC = 20,
    parameter int IDX_W   = 5,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    equiv_vector_sequencer_if.master bus
);

    localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);
    localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [SW-1:0]    r_settle;
    logic [IDX_W-1:0] r_vec_addr;
    logic [IN_W-1:0]  r_stim;
    logic             r_cmp_strobe;
    logic [IDX_W-1:0] r_cmp_idx;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic             r_first_fail_vld;
    logic [IDX_W-1:0] r_first_fail_idx;

    logic [OUT_W-1:0] w_diff;
    logic             w_mismatch;

    // Bitwise compare of the two DUT outputs over the full output width.
    assign w_diff     = bus.y_ref ^ bus.y_syn;
    assign w_mismatch = |w_diff;

    // Run sequencing: every output is a register updated with the state.
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_settle         <= '0;
            r_vec_addr       <= '0;
            r_stim           <= '0;
            r_cmp_strobe     <= 1'b0;
            r_cmp_idx        <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_mismatch_cnt   <= '0;
            r_first_fail_vld <= 1'b0;
            r_first_fail_idx <= '0;
        end else if (bus.abort) begin
            // Abort drops back to IDLE; statistics stay for debug.
            r_state      <= S_IDLE;
            r_stim       <= '0;
            r_cmp_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cmp_strobe <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state          <= S_FETCH;
                        r_idx            <= '0;
                        r_vec_addr       <= '0;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_mismatch_cnt   <= '0;
                        r_first_fail_vld <= 1'b0;
                        r_first_fail_idx <= '0;
                    end
                end
                S_FETCH: begin
                    // ROM samples vec_addr on this edge; data is valid in APPLY.
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    r_stim   <= bus.vec_data;
                    r_settle <= SETTLE_INIT;
                    if (SETTLE == 0) begin
                        r_state      <= S_COMPARE;
                        r_cmp_strobe <= 1'b1;
                        r_cmp_idx    <= r_idx;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_settle == SW'(1)) begin
                        r_state      <= S_COMPARE;
                        r_cmp_strobe <= 1'b1;
                        r_cmp_idx    <= r_idx;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (w_mismatch) begin
                        if (r_mismatch_cnt != '1) begin
                            r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                        end
                        if (!r_first_fail_vld) begin
                            r_first_fail_vld <= 1'b1;
                            r_first_fail_idx <= r_idx;
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_FETCH;
                        r_idx      <= r_idx + 1'b1;
                        r_vec_addr <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; pass is the only combinational status output.
    // NOTE: pass is a continuous assign of a pure expression, so no latch can
    // be inferred and it is 0 whenever done is 0 (including while busy).
    assign bus.vec_addr       = r_vec_addr;
    assign bus.stim           = r_stim;
    assign bus.cmp_strobe     = r_cmp_strobe;
    assign bus.cmp_idx        = r_cmp_idx;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_done && (r_mismatch_cnt == '0);
    assign bus.mismatch_cnt   = r_mismatch_cnt;
    assign bus.first_fail_vld = r_first_fail_vld;
    assign bus.first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_equiv_vector_sequencer.sv
// Bench for equiv_vector_sequencer. Two instances: the default configuration
// (20 vectors, settle 2, 8-bit counter) and a small one (4 vectors, settle 0,
// 2-bit counter). Each run pushes its expected compares (cycle, index) into a
// per-instance queue; monitors pop and compare on every cmp_strobe.
module tb_equiv_vector_sequencer;

    localparam int IN_W  = 79;
    localparam int OUT_W = 152;
    localparam int N0 = 20, S0 = 2, X0 = 5, C0 = 8;
    localparam int N1 = 4,  S1 = 0, X1 = 2, C1 = 2;

    typedef struct {
        int cyc;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t pop0;
    exp_t pop1;
    logic [IN_W-1:0] rom0 [N0];
    logic [IN_W-1:0] rom1 [N1];
    logic [31:0] fail0 = '0;
    logic [31:0] fail1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    equiv_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(X0), .CNT_W(C0)) bus0 ();
    equiv_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(X1), .CNT_W(C1)) bus1 ();

    equiv_vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(N0), .IDX_W(X0), .SETTLE(S0), .CNT_W(C0)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    equiv_vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(N1), .IDX_W(X1), .SETTLE(S1), .CNT_W(C1)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    // Reference DUT: an arbitrary fixed function of the stimulus.
    function automatic logic [OUT_W-1:0] y_model(input logic [IN_W-1:0] s);
        return {s[72:0], ~s};
    endfunction

    // Synthesised DUT differs by one bit on vectors flagged in 'fails';
    // the vector index is carried in the low bits of every ROM word.
    function automatic logic [OUT_W-1:0] flip_model(input logic [IN_W-1:0] s,
                                                     input logic [31:0] fails,
                                                     input int tag_bits);
        int t;
        logic [OUT_W-1:0] m;
        t = int'(s[4:0]) % (1 << tag_bits);
        m = '0;
        if (fails[t]) m[(t * 37 + 11) % OUT_W] = 1'b1;
        return m;
    endfunction

    // Synchronous vector ROMs and the two DUT models per instance.
    always @(posedge clk) bus0.vec_data <= rom0[bus0.vec_addr];
    always @(posedge clk) bus1.vec_data <= rom1[bus1.vec_addr];
    assign bus0.y_ref = y_model(bus0.stim);
    assign bus0.y_syn = y_model(bus0.stim) ^ flip_model(bus0.stim, fail0, X0);
    assign bus1.y_ref = y_model(bus1.stim);
    assign bus1.y_syn = y_model(bus1.stim) ^ flip_model(bus1.stim, fail1, X1);

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor for instance 0.
    always @(negedge clk) begin
        if (bus0.cmp_strobe === 1'b1) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_strobe", bus0.cmp_strobe, 1'b0);
            end else begin
                pop0 = q0.pop_front();
                check("u0_cmp_idx", bus0.cmp_idx, pop0.idx);
                check("u0_cmp_cycle", cyc, pop0.cyc);
                check("u0_cmp_stim", bus0.stim, rom0[pop0.idx]);
                check("u0_cmp_vec_addr", bus0.vec_addr, pop0.idx);
                check("u0_cmp_busy_pass", {bus0.busy, bus0.pass}, 2'b10);
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clk) begin
        if (bus1.cmp_strobe === 1'b1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_strobe", bus1.cmp_strobe, 1'b0);
            end else begin
                pop1 = q1.pop_front();
                check("u1_cmp_idx", bus1.cmp_idx, pop1.idx);
                check("u1_cmp_cycle", cyc, pop1.cyc);
                check("u1_cmp_stim", bus1.stim, rom1[pop1.idx]);
                check("u1_cmp_vec_addr", bus1.vec_addr, pop1.idx);
                check("u1_cmp_busy_pass", {bus1.busy, bus1.pass}, 2'b10);
            end
        end
    end

    task automatic fill0();
        logic [95:0] r;
        for (int i = 0; i < N0; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            rom0[i] = r[IN_W-1:0];
            rom0[i][X0-1:0] = X0'(i);
        end
    endtask

    task automatic fill1();
        logic [95:0] r;
        for (int i = 0; i < N1; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            rom1[i] = r[IN_W-1:0];
            rom1[i][X1-1:0] = X1'(i);
        end
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 5000 && cyc < c; i++) @(negedge clk);
    endtask

    task automatic check_zero0(input string t);
        check({t, "_stim"}, bus0.stim, '0);
        check({t, "_vec_addr"}, bus0.vec_addr, '0);
        check({t, "_strobe"}, bus0.cmp_strobe, 1'b0);
        check({t, "_cmp_idx"}, bus0.cmp_idx, '0);
        check({t, "_busy_done_pass"}, {bus0.busy, bus0.done, bus0.pass}, 3'b000);
        check({t, "_cnt"}, bus0.mismatch_cnt, '0);
        check({t, "_first_fail"}, {bus0.first_fail_vld, bus0.first_fail_idx}, '0);
    endtask

    // One complete run on instance 0; expected statistics come from 'fails'.
    task automatic run0(input logic [31:0] fails, input bit extra_start);
        int e, nf, ff, sat;
        fail0 = fails;
        nf = 0;
        ff = 0;
        for (int k = N0 - 1; k >= 0; k--) if (fails[k]) begin nf++; ff = k; end
        sat = (1 << C0) - 1;
        bus0.start = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < N0; k++) q0.push_back('{e + k * (S0 + 3) + S0 + 2, k});
        @(negedge clk);
        bus0.start = 1'b0;
        check("u0_start_busy_done", {bus0.busy, bus0.done}, 2'b10);
        check("u0_start_clear", {bus0.mismatch_cnt, bus0.first_fail_vld, bus0.first_fail_idx}, '0);
        if (extra_start) begin
            wait_until(e + (N0 * (S0 + 3)) / 2);
            bus0.start = 1'b1;
            @(negedge clk);
            bus0.start = 1'b0;
        end
        for (int i = 0; i < 4 * N0 * (S0 + 3) && bus0.done !== 1'b1; i++) @(negedge clk);
        check("u0_done", bus0.done, 1'b1);
        check("u0_done_cycle", cyc, e + N0 * (S0 + 3));
        check("u0_done_busy", bus0.busy, 1'b0);
        check("u0_pass", bus0.pass, nf == 0);
        check("u0_mismatch_cnt", bus0.mismatch_cnt, (nf > sat) ? sat : nf);
        check("u0_first_fail_vld", bus0.first_fail_vld, nf != 0);
        check("u0_first_fail_idx", bus0.first_fail_idx, ff);
        check("u0_done_stim_held", bus0.stim, rom0[N0-1]);
        check("u0_queue_drained", q0.size(), 0);
        q0.delete();
    endtask

    task automatic run1(input logic [31:0] fails, input bit extra_start);
        int e, nf, ff, sat;
        fail1 = fails;
        nf = 0;
        ff = 0;
        for (int k = N1 - 1; k >= 0; k--) if (fails[k]) begin nf++; ff = k; end
        sat = (1 << C1) - 1;
        bus1.start = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < N1; k++) q1.push_back('{e + k * (S1 + 3) + S1 + 2, k});
        @(negedge clk);
        bus1.start = 1'b0;
        check("u1_start_busy_done", {bus1.busy, bus1.done}, 2'b10);
        check("u1_start_clear", {bus1.mismatch_cnt, bus1.first_fail_vld, bus1.first_fail_idx}, '0);
        if (extra_start) begin
            wait_until(e + 1);
            bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
        end
        for (int i = 0; i < 4 * N1 * (S1 + 3) && bus1.done !== 1'b1; i++) @(negedge clk);
        check("u1_done", bus1.done, 1'b1);
        check("u1_done_cycle", cyc, e + N1 * (S1 + 3));
        check("u1_done_busy", bus1.busy, 1'b0);
        check("u1_pass", bus1.pass, nf == 0);
        check("u1_mismatch_cnt", bus1.mismatch_cnt, (nf > sat) ? sat : nf);
        check("u1_first_fail_vld", bus1.first_fail_vld, nf != 0);
        check("u1_first_fail_idx", bus1.first_fail_idx, ff);
        check("u1_done_stim_held", bus1.stim, rom1[N1-1]);
        check("u1_queue_drained", q1.size(), 0);
        q1.delete();
    endtask

    // Abort during the first WAIT cycle of vector 5 (vectors 1 and 4 fail).
    task automatic abort_test0();
        int e;
        fail0 = 32'h0000_0212;
        bus0.start = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < 5; k++) q0.push_back('{e + k * (S0 + 3) + S0 + 2, k});
        @(negedge clk);
        bus0.start = 1'b0;
        wait_until(e + 5 * (S0 + 3) + 2);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        check("abort_busy_done", {bus0.busy, bus0.done}, 2'b00);
        check("abort_stim", bus0.stim, '0);
        check("abort_cnt_kept", bus0.mismatch_cnt, 2);
        check("abort_first_fail_kept", {bus0.first_fail_vld, bus0.first_fail_idx}, {1'b1, 5'd1});
        repeat (3 * (S0 + 3)) @(negedge clk);
        check("abort_idle_busy", bus0.busy, 1'b0);
        check("abort_queue", q0.size(), 0);
        q0.delete();
    endtask

    // Reset while instance 0 shows the compare of vector 7 (a failing one).
    task automatic reset_test0();
        int e;
        fail0 = 32'h0000_0080;
        bus0.start = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < 8; k++) q0.push_back('{e + k * (S0 + 3) + S0 + 2, k});
        @(negedge clk);
        bus0.start = 1'b0;
        wait_until(e + 7 * (S0 + 3) + S0 + 2);
        check("pre_rst_strobe", bus0.cmp_strobe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_zero0("midrst");
        rst = 1'b0;
        repeat (2 * (S0 + 3)) @(negedge clk);
        check("midrst_idle_busy", bus0.busy, 1'b0);
        check("midrst_queue", q0.size(), 0);
        q0.delete();
    endtask

    initial begin
        fill0();
        fill1();
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_zero0("rst0");
        check("rst1_status", {bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.cmp_strobe}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Identical DUTs, then the two-mismatch run restarted from DONE with a
        // start pulse issued while busy.
        run0(32'h0, 1'b0);
        run0((32'h1 << 3) | (32'h1 << 17), 1'b1);

        // Abort mid-run, then a clean rerun with cleared counters.
        abort_test0();
        run0((32'h1 << 3) | (32'h1 << 17), 1'b0);

        // Randomised ROM contents and mismatch patterns.
        repeat (3) begin
            fill0();
            run0($urandom() & ((32'h1 << N0) - 1), 1'(($urandom() >> 4) & 1));
        end

        // Abort and start in the same cycle from DONE: abort wins.
        run0(32'h0, 1'b0);
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        check("abort_start_status", {bus0.busy, bus0.done, bus0.pass}, 3'b000);
        check("abort_start_stim", bus0.stim, '0);
        repeat (10) @(negedge clk);
        check("abort_start_idle", bus0.busy, 1'b0);

        // Small instance: saturation, zero settle, busy-start ignored.
        run1(32'hF, 1'b0);
        run1(32'h0, 1'b1);
        repeat (4) begin
            fill1();
            run1($urandom() & 32'hF, 1'(($urandom() >> 3) & 1));
        end

        reset_test0();
        run0(32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
